// File: rtl/multicycle_ctrl.sv
// Multicycle RV32I control FSM: sequences the shared ALU, memory port and register file.
// Optional jal support is built when MULTICYCLE_JAL_EN is defined.
module multicycle_ctrl (
    input  logic       clk,
    input  logic       rst,
    input  logic [6:0] op,
    input  logic       zero,
    input  logic       mem_ready,
    output logic       PCWrite,
    output logic       AdrSrc,
    output logic       MemWrite,
    output logic       IRWrite,
    output logic [1:0] ResultSrc,
    output logic [1:0] ALUSrcA,
    output logic [1:0] ALUSrcB,
    output logic [1:0] ImmSrc,
    output logic       RegWrite,
    output logic [1:0] ALUOp,
    output logic       illegal_op,
    output logic [3:0] state
);

    typedef enum logic [3:0] {
        S_FETCH    = 4'd0,
        S_DECODE   = 4'd1,
        S_MEMADR   = 4'd2,
        S_MEMREAD  = 4'd3,
        S_MEMWB    = 4'd4,
        S_MEMWRITE = 4'd5,
        S_EXECR    = 4'd6,
        S_ALUWB    = 4'd7,
        S_EXECI    = 4'd8,
        S_JAL      = 4'd9,
        S_BEQ      = 4'd10
    } state_t;

    localparam logic [6:0] OP_LOAD   = 7'b0000011;
    localparam logic [6:0] OP_STORE  = 7'b0100011;
    localparam logic [6:0] OP_RTYPE  = 7'b0110011;
    localparam logic [6:0] OP_ITYPE  = 7'b0010011;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;
    localparam logic [6:0] OP_JAL    = 7'b1101111;

    state_t state_q;
    state_t state_d;
    state_t out_state;
    logic   illegal_q;
    logic   set_illegal;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= S_FETCH;
            illegal_q <= 1'b0;
        end else begin
            state_q <= state_d;
            if (set_illegal)
                illegal_q <= 1'b1;
        end
    end

    always_comb begin
        state_d     = S_FETCH;
        set_illegal = 1'b0;
        case (state_q)
            S_FETCH:    state_d = mem_ready ? S_DECODE : S_FETCH;
            S_DECODE: begin
                case (op)
                    OP_LOAD, OP_STORE: state_d = S_MEMADR;
                    OP_RTYPE:          state_d = S_EXECR;
                    OP_ITYPE:          state_d = S_EXECI;
                    OP_BRANCH:         state_d = S_BEQ;
`ifdef MULTICYCLE_JAL_EN
                    OP_JAL:            state_d = S_JAL;
`endif
                    default: begin
                        state_d     = S_FETCH;
                        set_illegal = 1'b1;
                    end
                endcase
            end
            S_MEMADR:   state_d = (op == OP_STORE) ? S_MEMWRITE : S_MEMREAD;
            S_MEMREAD:  state_d = mem_ready ? S_MEMWB : S_MEMREAD;
            S_MEMWB:    state_d = S_FETCH;
            S_MEMWRITE: state_d = mem_ready ? S_FETCH : S_MEMWRITE;
            S_EXECR:    state_d = S_ALUWB;
            S_EXECI:    state_d = S_ALUWB;
            S_ALUWB:    state_d = S_FETCH;
`ifdef MULTICYCLE_JAL_EN
            S_JAL:      state_d = S_ALUWB;
`endif
            S_BEQ:      state_d = S_FETCH;
            default:    state_d = S_FETCH;
        endcase
    end

    // Reset forces FETCH decoding so an abandoned instruction cannot strobe writes.
    assign out_state = rst ? S_FETCH : state_q;

    always_comb begin
        PCWrite   = 1'b0;
        AdrSrc    = 1'b0;
        MemWrite  = 1'b0;
        IRWrite   = 1'b0;
        ResultSrc = 2'b00;
        ALUSrcA   = 2'b00;
        ALUSrcB   = 2'b00;
        RegWrite  = 1'b0;
        ALUOp     = 2'b00;
        case (out_state)
            S_FETCH: begin
                ALUSrcB   = 2'b10;
                ResultSrc = 2'b10;
                IRWrite   = mem_ready;
                PCWrite   = mem_ready;
            end
            S_DECODE: begin
                ALUSrcA = 2'b01;
                ALUSrcB = 2'b01;
            end
            S_MEMADR: begin
                ALUSrcA = 2'b10;
                ALUSrcB = 2'b01;
            end
            S_MEMREAD:  AdrSrc = 1'b1;
            S_MEMWB: begin
                ResultSrc = 2'b01;
                RegWrite  = 1'b1;
            end
            S_MEMWRITE: begin
                AdrSrc   = 1'b1;
                MemWrite = 1'b1;
            end
            S_EXECR: begin
                ALUSrcA = 2'b10;
                ALUOp   = 2'b10;
            end
            S_EXECI: begin
                ALUSrcA = 2'b10;
                ALUSrcB = 2'b01;
                ALUOp   = 2'b10;
            end
            S_ALUWB:    RegWrite = 1'b1;
`ifdef MULTICYCLE_JAL_EN
            S_JAL: begin
                ALUSrcA = 2'b01;
                ALUSrcB = 2'b10;
                PCWrite = 1'b1;
            end
`endif
            S_BEQ: begin
                ALUSrcA = 2'b10;
                ALUOp   = 2'b01;
                PCWrite = zero;
            end
            default: ;
        endcase
    end

    always_comb begin
        ImmSrc = 2'b00;
        case (op)
            OP_STORE:  ImmSrc = 2'b01;
            OP_BRANCH: ImmSrc = 2'b10;
`ifdef MULTICYCLE_JAL_EN
            OP_JAL:    ImmSrc = 2'b11;
`endif
            default:   ImmSrc = 2'b00;
        endcase
    end

    assign illegal_op = illegal_q;
    assign state      = state_q;

endmodule

// File: tb/tb_multicycle_ctrl.sv
// Scoreboard bench for multicycle_ctrl: each driven cycle queues its expected outputs,
// which are popped and compared at the following falling edge.
module tb_multicycle_ctrl;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic [6:0] op = 7'd0;
    logic       zero = 1'b0;
    logic       mem_ready = 1'b1;
    logic       PCWrite, AdrSrc, MemWrite, IRWrite, RegWrite, illegal_op;
    logic [1:0] ResultSrc, ALUSrcA, ALUSrcB, ImmSrc, ALUOp;
    logic [3:0] state;

    multicycle_ctrl dut (
        .clk(clk), .rst(rst), .op(op), .zero(zero), .mem_ready(mem_ready),
        .PCWrite(PCWrite), .AdrSrc(AdrSrc), .MemWrite(MemWrite), .IRWrite(IRWrite),
        .ResultSrc(ResultSrc), .ALUSrcA(ALUSrcA), .ALUSrcB(ALUSrcB), .ImmSrc(ImmSrc),
        .RegWrite(RegWrite), .ALUOp(ALUOp), .illegal_op(illegal_op), .state(state)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic       known;
        logic [3:0] st;
        logic       pcw, adr, mw, irw;
        logic [1:0] rs, sa, sb, imm;
        logic       rw;
        logic [1:0] aluop;
        logic       ill;
    } exp_t;

    exp_t sb_q[$];
    int   n_chk  = 0;
    int   n_pass = 0;
    logic ill_m  = 1'b0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp)
            $display("FAIL %s: got %0h, expected %0h (t=%0t)", tag, got, exp, $time);
        else
            n_pass++;
    endtask

    function automatic logic legal(input logic [6:0] o);
        case (o)
            7'b0000011, 7'b0100011, 7'b0110011, 7'b0010011, 7'b1100011: return 1'b1;
`ifdef MULTICYCLE_JAL_EN
            7'b1101111: return 1'b1;
`endif
            default: return 1'b0;
        endcase
    endfunction

    function automatic exp_t mk(input logic known, input logic r, input logic [3:0] st,
                                input logic mr, input logic z, input logic [6:0] o,
                                input logic ill);
        exp_t e;
        logic [3:0] eff;
        e = '0;
        e.known = known;
        e.st    = st;
        e.ill   = ill;
        case (o)
            7'b0100011: e.imm = 2'b01;
            7'b1100011: e.imm = 2'b10;
`ifdef MULTICYCLE_JAL_EN
            7'b1101111: e.imm = 2'b11;
`endif
            default:    e.imm = 2'b00;
        endcase
        eff = r ? 4'd0 : st;
        case (eff)
            4'd0:  begin e.sb = 2'b10; e.rs = 2'b10; e.irw = mr; e.pcw = mr; end
            4'd1:  begin e.sa = 2'b01; e.sb = 2'b01; end
            4'd2:  begin e.sa = 2'b10; e.sb = 2'b01; end
            4'd3:  begin e.adr = 1'b1; end
            4'd4:  begin e.rs = 2'b01; e.rw = 1'b1; end
            4'd5:  begin e.adr = 1'b1; e.mw = 1'b1; end
            4'd6:  begin e.sa = 2'b10; e.aluop = 2'b10; end
            4'd7:  begin e.rw = 1'b1; end
            4'd8:  begin e.sa = 2'b10; e.sb = 2'b01; e.aluop = 2'b10; end
            4'd9:  begin e.sa = 2'b01; e.sb = 2'b10; e.pcw = 1'b1; end
            4'd10: begin e.sa = 2'b10; e.aluop = 2'b01; e.pcw = z; end
            default: ;
        endcase
        return e;
    endfunction

    always @(negedge clk) begin
        if (sb_q.size() > 0) begin
            exp_t e;
            e = sb_q.pop_front();
            if (e.known) begin
                check("state", state, e.st);
                check("illegal_op", illegal_op, e.ill);
            end
            check("PCWrite", PCWrite, e.pcw);
            check("AdrSrc", AdrSrc, e.adr);
            check("MemWrite", MemWrite, e.mw);
            check("IRWrite", IRWrite, e.irw);
            check("ResultSrc", ResultSrc, e.rs);
            check("ALUSrcA", ALUSrcA, e.sa);
            check("ALUSrcB", ALUSrcB, e.sb);
            check("ImmSrc", ImmSrc, e.imm);
            check("RegWrite", RegWrite, e.rw);
            check("ALUOp", ALUOp, e.aluop);
        end
    end

    task automatic cyc(input logic r, input logic mr, input logic [6:0] o, input logic z,
                       input logic [3:0] st, input logic known);
        rst       = r;
        mem_ready = mr;
        op        = o;
        zero      = z;
        sb_q.push_back(mk(known, r, st, mr, z, o, ill_m));
        @(posedge clk);
        #1;
        if (r)
            ill_m = 1'b0;
        else if (st == 4'd1 && !legal(o))
            ill_m = 1'b1;
    endtask

    function automatic logic rnd();
        return 1'($urandom_range(0, 1));
    endfunction

    task automatic do_instr(input logic [6:0] o, input logic z, input int fw, input int mw);
        for (int i = 0; i < fw; i++) cyc(1'b0, 1'b0, o, z, 4'd0, 1'b1);
        cyc(1'b0, 1'b1, o, z, 4'd0, 1'b1);
        cyc(1'b0, rnd(), o, z, 4'd1, 1'b1);
        case (o)
            7'b0000011: begin
                cyc(1'b0, rnd(), o, z, 4'd2, 1'b1);
                for (int i = 0; i < mw; i++) cyc(1'b0, 1'b0, o, z, 4'd3, 1'b1);
                cyc(1'b0, 1'b1, o, z, 4'd3, 1'b1);
                cyc(1'b0, rnd(), o, z, 4'd4, 1'b1);
            end
            7'b0100011: begin
                cyc(1'b0, rnd(), o, z, 4'd2, 1'b1);
                for (int i = 0; i < mw; i++) cyc(1'b0, 1'b0, o, z, 4'd5, 1'b1);
                cyc(1'b0, 1'b1, o, z, 4'd5, 1'b1);
            end
            7'b0110011: begin
                cyc(1'b0, rnd(), o, z, 4'd6, 1'b1);
                cyc(1'b0, rnd(), o, z, 4'd7, 1'b1);
            end
            7'b0010011: begin
                cyc(1'b0, rnd(), o, z, 4'd8, 1'b1);
                cyc(1'b0, rnd(), o, z, 4'd7, 1'b1);
            end
            7'b1100011: cyc(1'b0, rnd(), o, z, 4'd10, 1'b1);
`ifdef MULTICYCLE_JAL_EN
            7'b1101111: begin
                cyc(1'b0, rnd(), o, z, 4'd9, 1'b1);
                cyc(1'b0, rnd(), o, z, 4'd7, 1'b1);
            end
`endif
            default: ;
        endcase
    endtask

    initial begin
        @(posedge clk);
        #1;
        cyc(1'b1, 1'b1, 7'd0, 1'b0, 4'd0, 1'b0);
        cyc(1'b1, 1'b0, 7'd0, 1'b0, 4'd0, 1'b1);
        do_instr(7'b0000011, 1'b0, 0, 0);
        do_instr(7'b0100011, 1'b0, 0, 3);
        do_instr(7'b1100011, 1'b1, 0, 0);
        do_instr(7'b1100011, 1'b0, 1, 0);
        do_instr(7'b0110011, 1'b0, 0, 0);
        do_instr(7'b0010011, 1'b1, 0, 0);
        do_instr(7'b1101111, 1'b0, 0, 0);
        do_instr(7'b1111111, 1'b0, 0, 0);
        do_instr(7'b0000011, 1'b1, 2, 1);
        do_instr(7'b0100011, 1'b0, 1, 0);
        // Abandon a load while it waits on memory.
        cyc(1'b0, 1'b1, 7'b0000011, 1'b0, 4'd0, 1'b1);
        cyc(1'b0, 1'b1, 7'b0000011, 1'b0, 4'd1, 1'b1);
        cyc(1'b0, 1'b1, 7'b0000011, 1'b0, 4'd2, 1'b1);
        cyc(1'b0, 1'b0, 7'b0000011, 1'b0, 4'd3, 1'b1);
        cyc(1'b0, 1'b0, 7'b0000011, 1'b0, 4'd3, 1'b1);
        cyc(1'b1, 1'b0, 7'b0000011, 1'b0, 4'd3, 1'b1);
        cyc(1'b0, 1'b0, 7'b0000011, 1'b0, 4'd0, 1'b1);
        do_instr(7'b0000011, 1'b0, 0, 0);
        do_instr(7'b1100011, 1'b1, 0, 0);
        repeat (3) @(negedge clk);
        check("scoreboard_drain", sb_q.size(), 0);
        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule

// File: doc/multicycle_ctrl.md
# multicycle_ctrl

Control FSM for the multicycle RV32I core variant. It sequences one shared ALU, the unified instruction/data memory port and the register file over several cycles per instruction, in place of the single-cycle main decoder. It also waits on a memory-ready handshake for every memory access and flags unsupported opcodes. It sits between the instruction register (`op`, `zero` from the ALU) and the datapath mux and enable controls.

## Interface
Parameters: none.

Ports. Clock and reset are listed first. One clock; reset is synchronous and active-high.
- `clk`  in  1  core clock; all state changes on the rising edge
- `rst`  in  1  synchronous, active-high reset
- `op`  in  7  opcode field of the instruction register
- `zero`  in  1  ALU zero flag
- `mem_ready`  in  1  memory has completed the current access this cycle
- `PCWrite`  out  1  PC register enable
- `AdrSrc`  out  1  memory address select: 0 = PC, 1 = ALUOut
- `MemWrite`  out  1  memory write strobe
- `IRWrite`  out  1  instruction and OldPC register enable
- `ResultSrc`  out  2  result select: 00 = ALUOut, 01 = Data, 10 = ALUResult
- `ALUSrcA`  out  2  ALU A operand: 00 = PC, 01 = OldPC, 10 = rd1
- `ALUSrcB`  out  2  ALU B operand: 00 = rd2, 01 = imm, 10 = constant 4
- `ImmSrc`  out  2  immediate format: I = 00, S = 01, B = 10, J = 11
- `RegWrite`  out  1  register file write enable
- `ALUOp`  out  2  to the ALU decoder: 00 = add, 01 = subtract/compare, 10 = funct-decoded
- `illegal_op`  out  1  sticky flag, set when an unsupported opcode is decoded
- `state`  out  4  current state, for debug and the bench

## Operation
- States and encodings: FETCH = 0, DECODE = 1, MEMADR = 2, MEMREAD = 3, MEMWB = 4, MEMWRITE = 5, EXECR = 6, ALUWB = 7, EXECI = 8, JAL = 9, BEQ = 10. Encodings 11–15 are unreachable; if reached, the next state is FETCH.
- All control outputs are 0 unless listed for the state below.
- FETCH: `AdrSrc=0`, `ALUSrcA=00`, `ALUSrcB=10`, `ALUOp=00`, `ResultSrc=10`.
  - `IRWrite` and `PCWrite` are both equal to `mem_ready`.
  - Next state is DECODE if `mem_ready`, otherwise stay in FETCH.
- DECODE: `ALUSrcA=01`, `ALUSrcB=01`, `ALUOp=00` (computes the branch/jump target into ALUOut). Next state by `op`:
  - 0000011 (load) or 0100011 (store) → MEMADR
  - 0110011 (R-type) → EXECR
  - 0010011 (I-type ALU) → EXECI
  - 1100011 (branch) → BEQ
  - 1101111 (jal) → JAL
  - any other opcode → FETCH, and `illegal_op` is set
- MEMADR: `ALUSrcA=10`, `ALUSrcB=01`, `ALUOp=00`. Next state is MEMREAD for a load, MEMWRITE for a store.
- MEMREAD: `ResultSrc=00`, `AdrSrc=1`. Next state is MEMWB if `mem_ready`, otherwise stay.
- MEMWB: `ResultSrc=01`, `RegWrite=1`. Next state is FETCH.
- MEMWRITE: `ResultSrc=00`, `AdrSrc=1`, `MemWrite=1`.
  - `MemWrite` stays asserted until `mem_ready`.
  - Next state is FETCH if `mem_ready`, otherwise stay.
- EXECR: `ALUSrcA=10`, `ALUSrcB=00`, `ALUOp=10`. Next state is ALUWB.
- EXECI: `ALUSrcA=10`, `ALUSrcB=01`, `ALUOp=10`. Next state is ALUWB.
- ALUWB: `ResultSrc=00`, `RegWrite=1`. Next state is FETCH.
- JAL: `ALUSrcA=01`, `ALUSrcB=10`, `ALUOp=00`, `ResultSrc=00`, `PCWrite=1`. Next state is ALUWB, which writes PC+4 into rd.
- BEQ: `ALUSrcA=10`, `ALUSrcB=00`, `ALUOp=01`, `ResultSrc=00`, `PCWrite=zero`. Next state is FETCH.
- `ImmSrc` is decoded combinationally from `op` in every state:
  - store → 01, branch → 10, jal → 11
  - all other opcodes → 00
- `illegal_op` is cleared only by `rst`.

## Timing
- Reset: when `rst` is high at a clock edge, `state` becomes FETCH and `illegal_op` becomes 0.
- While `rst` is high, outputs take their FETCH values: only `ALUSrcB=10` and `ResultSrc=10` are nonzero, plus `IRWrite`/`PCWrite` following `mem_ready`.
- `rst` asserted mid-instruction (including during a memory wait) abandons the instruction. No further `RegWrite` or `MemWrite` is asserted after the reset edge.
- Cycles per instruction with `mem_ready` held high: load 5, store 4, R-type 4, I-type 4, jal 4, branch 3, illegal 2.
- Each cycle `mem_ready` is low in FETCH, MEMREAD or MEMWRITE adds exactly one cycle. Outputs stay stable throughout the wait.
- Outputs are Moore-decoded from `state`, except:
  - `IRWrite` and `PCWrite` in FETCH depend on `mem_ready`
  - `PCWrite` in BEQ depends on `zero`
  - `ImmSrc` depends on `op`
- `op` only needs to be valid in DECODE and later states. The instruction register is stable after FETCH.

## Configuration
- Macro: `MULTICYCLE_JAL_EN`.
- Defined: the JAL state exists and opcode 1101111 is supported as described above.
- Undefined:
  - the JAL state is not built
  - opcode 1101111 is treated as illegal (DECODE → FETCH, `illegal_op` set)
  - `ImmSrc` for 1101111 is 00
  - encoding 9 becomes unreachable and, if reached, goes to FETCH

## Test plan
- Reset then lw (`op=0000011`) with `mem_ready=1`: state sequence 0,1,2,3,4,0; `RegWrite=1` only in state 4 with `ResultSrc=01`.
- sw (`op=0100011`) with `mem_ready` low for 3 cycles in MEMWRITE: `MemWrite` high for exactly 4 cycles, `AdrSrc=1` throughout, `ImmSrc=01`, no `RegWrite`.
- beq with `zero=1`, then with `zero=0`: `PCWrite` high in BEQ only in the first case; 3 cycles each; `ALUOp=01`.
- R-type (0110011) then I-type (0010011): each takes 4 cycles with `ALUOp=10`; `ALUSrcB` is 00 and 01 respectively in the execute state.
- jal (1101111) with the macro defined: sequence 0,1,9,7,0 with `PCWrite=1` in state 9. With the macro undefined: sequence 0,1,0 and `illegal_op=1`.
- Illegal `op=1111111`: `illegal_op` stays set across later legal instructions. `rst` asserted during a MEMREAD wait returns state to 0 next cycle with `illegal_op=0` and no `RegWrite`.
